// File: rtl/fe_req_pkg.sv
// Shared register map and helpers for the front-end request controller.
package fe_req_pkg;

  typedef enum logic [1:0] {
    REG_PEND    = 2'd0,
    REG_ACK     = 2'd1,
    REG_ENABLE  = 2'd2,
    REG_HIGHEST = 2'd3
  } reg_addr_e;

  localparam int MAX_CHAN          = 32;
  localparam int HIGHEST_VALID_BIT = 31;

  // Lowest-numbered active channel in [4:0], "any active" flag in bit 31.
  function automatic logic [31:0] highest_word(input logic [MAX_CHAN-1:0] act);
    logic [4:0]  idx;
    logic [31:0] word;
    idx = '0;
    for (int i = MAX_CHAN - 1; i >= 0; i--) begin
      if (act[i]) idx = 5'(i);
    end
    word                    = '0;
    word[HIGHEST_VALID_BIT] = |act;
    word[4:0]               = idx;
    return word;
  endfunction

endpackage

// File: rtl/fe_req_ctrl_if.sv
// Avalon-MM slave bus carrying HPS accesses to the request controller.
interface fe_req_ctrl_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );
endinterface

// File: rtl/fe_req_chan.sv
// One request channel: synchroniser, level/edge detect, sticky pending and
// LED pulse stretcher.
module fe_req_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_W   = 20,
  parameter bit EDGE        = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rq_i,
  input  logic clr_i,
  output logic pending_o,
  output logic led_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;
  logic                   pend_q, pend_d;
  logic [STRETCH_W-1:0]   cnt_q, cnt_d;
  logic                   s;
  logic                   set;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rq_i};
    s      = sync_q[SYNC_STAGES-1];
    set    = EDGE ? (s & ~prev_q) : s;
    // A new set outranks a same-cycle acknowledge.
    pend_d = set | (pend_q & ~clr_i);
    if (s)                cnt_d = '1;
    else if (cnt_q != '0) cnt_d = cnt_q - STRETCH_W'(1);
    else                  cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= s;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_o = pend_q;
  assign led_o     = (cnt_q != '0);

endmodule

// File: rtl/fe_req_ctrl.sv
// Front-end request controller: NCHAN sticky request channels behind an
// Avalon-MM register block, with masked request word and interrupt.
module fe_req_ctrl
  import fe_req_pkg::*;
#(
  parameter int          NCHAN       = 3,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EDGE_MASK   = 32'h0,
  parameter int          STRETCH_W   = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCHAN-1:0] rq_in,
  output logic [31:0]      fe_req,
  output logic             irq,
  output logic [NCHAN-1:0] led,
  fe_req_ctrl_if.slave     avs
);

  logic [NCHAN-1:0] pend;
  logic [NCHAN-1:0] clr;
  logic [NCHAN-1:0] en_q, en_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      pend_ext, en_ext, act_ext;
  reg_addr_e        addr;
  logic             unused_wdata;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    fe_req_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .STRETCH_W   (STRETCH_W),
      .EDGE        (EDGE_MASK[g])
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .rq_i      (rq_in[g]),
      .clr_i     (clr[g]),
      .pending_o (pend[g]),
      .led_o     (led[g])
    );
  end

  assign addr         = reg_addr_e'(avs.avs_address);
  assign unused_wdata = ^avs.avs_writedata;

  always_comb begin
    pend_ext             = '0;
    pend_ext[NCHAN-1:0]  = pend;
    en_ext               = '0;
    en_ext[NCHAN-1:0]    = en_q;
    act_ext              = pend_ext & en_ext;
    irq_d                = |act_ext;

    clr  = '0;
    en_d = en_q;
    if (avs.avs_write) begin
      if (addr == REG_ACK)    clr  = avs.avs_writedata[NCHAN-1:0];
      if (addr == REG_ENABLE) en_d = avs.avs_writedata[NCHAN-1:0];
    end

    // Readdata reflects pre-edge state and holds between reads.
    rdata_d = rdata_q;
    if (avs.avs_read) begin
      case (addr)
        REG_PEND:    rdata_d = pend_ext;
        REG_ACK:     rdata_d = '0;
        REG_ENABLE:  rdata_d = en_ext;
        REG_HIGHEST: rdata_d = highest_word(act_ext);
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q    <= '1;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign fe_req           = act_ext;
  assign irq              = irq_q;
  assign avs.avs_readdata = rdata_q;

endmodule

// File: doc/fe_req_ctrl.md
Name: fe_req_ctrl

Overview:
- Parametrised front-end request controller. Generalises the fixed three-bit FE request word (ptr, ptp, dis340) and panel-extension LEDs to NCHAN channels.
- Per channel: synchronises the request, detects level or edge, holds a sticky pending bit, and stretches the LED pulse.
- Presents pending/enable/ack/priority registers on an Avalon-MM slave to the HPS, plus an interrupt line.
- Sits between the device cores' *_fe_data_rq outputs and the soc_system fe_req/panel_ext inputs.

Parameters:
- NCHAN, 3, number of request channels, 1..32.
- SYNC_STAGES, 2, synchroniser flops per input, 2..4.
- EDGE_MASK, 32'h0, bit i=1: channel i is rising-edge sticky; bit i=0: level.
- STRETCH_W, 20, LED stretch counter width (2^20-1 cycles ≈ 21 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rq_in  in  NCHAN  raw request inputs, asynchronous to clk.
- fe_req  out  32  pending & enable, zero-extended above NCHAN.
- irq  out  1  registered OR of fe_req.
- led  out  NCHAN  stretched activity indicators.
- avs_address  in  2  register select.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, fixed read latency 1.

Behaviour:
- Reset: one clock, clk. reset_n is asynchronous and active-low. While asserted, all state clears:
  - sync chains, prev, pending, counters = 0.
  - enable = low NCHAN bits set, rest 0.
  - irq = 0, avs_readdata = 0, fe_req = 0, led = 0.
- Deassertion is synchronised externally and is not this block's concern.
- Sync: rq_in[i] passes through SYNC_STAGES flops to give s[i]; prev[i] <= s[i] every cycle.
- Set condition:
  - Edge channel: s[i] & ~prev[i].
  - Level channel: s[i].
- Pending update: pending[i] <= set[i] | (pending[i] & ~clr[i]).
  - clr[i] = avs_write & address==1 & writedata[i].
  - Set wins over simultaneous clear.
  - A level channel still high re-pends the cycle after ack.
- Latency: with rq_in high before edge 1, s is high after edge SYNC_STAGES, pending is set at edge SYNC_STAGES+1, irq at edge SYNC_STAGES+2.
- fe_req = pending & enable, combinational from registers. Bits >= NCHAN are 0.
- Disabled channels still accumulate pending; they are masked only on fe_req, irq and HIGHEST.
- irq <= |(pending & enable).
- Stretch:
  - cnt[i] <= all-ones when s[i] = 1; else cnt[i]-1 when nonzero; else holds 0.
  - led[i] = (cnt[i] != 0). No wrap.
- Registers (32-bit; bits >= NCHAN read 0 and ignore writes):
  - 0 PEND: RO, raw pending.
  - 1 ACK: WO, write-1-to-clear pending; reads 0.
  - 2 ENABLE: RW.
  - 3 HIGHEST: RO. bit31 = any (pending & enable); bits[4:0] = lowest-numbered such channel, 0 if none.
- Read: avs_readdata is registered from the state before the edge of the avs_read cycle. Readdata holds its value when no read is issued.
- Simultaneous read and write to the same register return the pre-write value.
- Reset mid-operation aborts stretch and discards pending immediately. No partial state survives.

Decomposition:
- Package fe_req_pkg:
  - Register address constants REG_PEND=0, REG_ACK=1, REG_ENABLE=2, REG_HIGHEST=3.
  - MAX_CHAN=32, HIGHEST_VALID_BIT=31.
- Sub-module fe_req_chan, generated NCHAN times. Holds the sync chain, prev, the pending flop (inputs set-mode, clr, outputs pending) and the stretch counter (parameters SYNC_STAGES, STRETCH_W, EDGE).
- Top level holds the Avalon decode, enable register, priority encoder and irq.

Test Plan:
1. Reset values: NCHAN=3, hold reset_n low → fe_req=0, irq=0, led=0, ENABLE reads 0x7, PEND 0. Assert reset_n asynchronously mid-cycle → outputs clear with no clock edge.
2. Level latency: SYNC_STAGES=2, rq_in[1] high before edge 1 → PEND=0x2 after edge 3, irq=1 after edge 4, HIGHEST=0x80000001. Write ACK=0x2 while still high → PEND stays 0x2. Drop input, then ACK → PEND=0.
3. Edge sticky: EDGE_MASK=0x1, 1-cycle pulse on rq_in[0] → PEND=0x1 persists after input low. ACK write on the same edge as a new rising edge → bit stays 1.
4. Masking/priority: PEND=0x6, ENABLE=0x4 → fe_req=0x4, HIGHEST=0x80000002. ENABLE=0 → irq=0 one cycle later, PEND still 0x6.
5. Stretch: STRETCH_W=4, 1-cycle pulse on rq_in[2] → led[2] high for exactly 15 cycles after s rises. Repeat pulse mid-stretch → reloads to 15.
6. Width bounds: NCHAN=32, all rq_in high → PEND=0xFFFFFFFF, HIGHEST=0x80000000. NCHAN=3, write ENABLE=0xFFFFFFFF → reads 0x7.
